// File: rtl/la_rle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : la_rle_decoder
// Description : AXI-Stream sink that run-length decodes logic-analyzer capture
//               words and replays each sample one beat per output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module la_rle_decoder #(
    parameter int LA_WIDTH   = 24,
    parameter int CNT_WIDTH  = 8,
    parameter int LOST_WIDTH = 24
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst,
    input  logic [LA_WIDTH+CNT_WIDTH-1:0] s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    input  logic [1:0]                    s_tuser,
    input  logic                          dec_enable,
    input  logic [7:0]                    pkt_len,
    input  logic                          err_clr,
    output logic [LA_WIDTH-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   sync_cnt,
    output logic [LOST_WIDTH-1:0]         lost_cycles,
    output logic                          ovf_pulse,
    output logic                          pkt_err
);

    localparam logic [0:0]            c_IDLE     = 1'b0;
    localparam logic [0:0]            c_REPLAY   = 1'b1;
    localparam int                    SUM_W      = ((LOST_WIDTH > LA_WIDTH) ? LOST_WIDTH : LA_WIDTH) + 1;
    localparam logic [LOST_WIDTH-1:0] c_LOST_MAX = '1;

    logic [0:0]            state_q, state_d;
    logic                  ready_en_q;
    logic [CNT_WIDTH-1:0]  remain_q;
    logic [LA_WIDTH-1:0]   prev_data_q;
    logic [LA_WIDTH-1:0]   latch_q;
    logic [LA_WIDTH-1:0]   out_data_q;
    logic [15:0]           sync_cnt_q;
    logic [LOST_WIDTH-1:0] lost_cycles_q;
    logic                  ovf_pulse_q;
    logic [7:0]            beat_cnt_q;
    logic                  pkt_err_q;

    logic [CNT_WIDTH-1:0]  w_run;
    logic [LA_WIDTH-1:0]   w_dat;
    logic                  w_accept;
    logic                  w_is_sync;
    logic                  w_is_full;
    logic                  w_is_data;
    logic                  w_out_hs;
    logic                  w_last_beat;
    logic [7:0]            w_beat;
    logic                  w_len_chk;
    logic                  w_pkt_bad;
    logic [SUM_W-1:0]      w_lost_sum;
    logic                  w_lost_sat;
    logic                  w_unused;

    assign w_unused    = ^s_tuser;

    assign w_run       = s_tdata[LA_WIDTH+CNT_WIDTH-1:LA_WIDTH];
    assign w_dat       = s_tdata[LA_WIDTH-1:0];
    assign w_accept    = s_tvalid & s_tready;
    assign w_is_sync   = (s_tdata == '0);
    assign w_is_full   = (w_run == '0) && (w_dat != '0);
    assign w_is_data   = (w_run != '0);
    assign w_out_hs    = out_valid & out_ready;
    assign w_last_beat = w_out_hs && (remain_q == CNT_WIDTH'(1));

    assign w_beat      = beat_cnt_q + 8'd1;
    assign w_len_chk   = (pkt_len != 8'd0);
    // Error when tlast and the expected last beat disagree.
    assign w_pkt_bad   = w_accept && w_len_chk && (s_tlast != (w_beat == pkt_len));

    assign w_lost_sum  = SUM_W'(lost_cycles_q) + SUM_W'(w_dat);
    assign w_lost_sat  = (w_lost_sum > SUM_W'(c_LOST_MAX));

    assign out_data    = out_data_q;
    assign sync_cnt    = sync_cnt_q;
    assign lost_cycles = lost_cycles_q;
    assign ovf_pulse   = ovf_pulse_q;
    assign pkt_err     = pkt_err_q;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (w_accept && w_is_data) state_d = c_REPLAY;
            c_REPLAY: if (w_last_beat)           state_d = c_IDLE;
            default:                             state_d = c_IDLE;
        endcase
    end

    // ready_en_q keeps s_tready low while reset is asserted
    always_comb begin
        s_tready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            c_IDLE:   s_tready  = dec_enable & ready_en_q;
            c_REPLAY: out_valid = 1'b1;
            default: begin
                s_tready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            ready_en_q  <= 1'b0;
            remain_q    <= '0;
            prev_data_q <= '0;
            latch_q     <= '0;
            out_data_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (w_accept && w_is_data) begin
                remain_q   <= w_run;
                out_data_q <= prev_data_q;
                latch_q    <= w_dat;
            end else if (w_out_hs) begin
                remain_q <= remain_q - CNT_WIDTH'(1);
                if (w_last_beat) begin
                    prev_data_q <= latch_q;
                end
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            sync_cnt_q    <= '0;
            lost_cycles_q <= '0;
            ovf_pulse_q   <= 1'b0;
            beat_cnt_q    <= '0;
            pkt_err_q     <= 1'b0;
        end else begin
            ovf_pulse_q <= w_accept && w_is_full;
            if (w_accept && w_is_sync) begin
                sync_cnt_q <= sync_cnt_q + 16'd1;
            end
            if (w_accept && w_is_full) begin
                lost_cycles_q <= w_lost_sat ? c_LOST_MAX : w_lost_sum[LOST_WIDTH-1:0];
            end
            if (w_accept) begin
                beat_cnt_q <= (s_tlast || (w_len_chk && (w_beat == pkt_len))) ? 8'd0 : w_beat;
            end
            if (w_pkt_bad) begin
                pkt_err_q <= 1'b1;
            end else if (err_clr) begin
                pkt_err_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_la_rle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_rle_decoder
// Description : Directed self-checking bench for la_rle_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_rle_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [1:0]  s_tuser;
    logic        dec_enable;
    logic [7:0]  pkt_len;
    logic        err_clr;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sync_cnt;
    logic [23:0] lost_cycles;
    logic        ovf_pulse;
    logic        pkt_err;

    int n_pass  = 0;
    int n_total = 0;

    la_rle_decoder #(
        .LA_WIDTH   (24),
        .CNT_WIDTH  (8),
        .LOST_WIDTH (24)
    ) dut (
        .axis_clk    (clk),
        .axis_rst    (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .dec_enable  (dec_enable),
        .pkt_len     (pkt_len),
        .err_clr     (err_clr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sync_cnt    (sync_cnt),
        .lost_cycles (lost_cycles),
        .ovf_pulse   (ovf_pulse),
        .pkt_err     (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one word and return at the falling edge after it is accepted.
    task automatic send(input logic [31:0] w, input logic last);
        int waitc = 0;
        s_tdata  = w;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) chk("tready_timeout", 32'(waitc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Drain a replay run, checking data/tready every cycle and the handshake count.
    task automatic collect(input string tag, input logic [23:0] exp, input int n, input bit toggle);
        int hs  = 0;
        int cyc = 0;
        bit rdy = 1'b1;
        while (out_valid && cyc < 100) begin
            out_ready = toggle ? rdy : 1'b1;
            chk({tag, "_data"}, 32'(out_data), 32'(exp));
            chk({tag, "_tready"}, 32'(s_tready), 32'd0);
            if (out_ready) hs++;
            @(negedge clk);
            cyc++;
            rdy = ~rdy;
        end
        out_ready = 1'b1;
        chk({tag, "_beats"}, 32'(hs), 32'(n));
    endtask

    initial begin
        rst        = 1'b1;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tuser    = 2'b11;
        dec_enable = 1'b1;
        pkt_len    = 8'd0;
        err_clr    = 1'b0;
        out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_tready",  32'(s_tready),    32'd0);
        chk("rst_ovalid",  32'(out_valid),   32'd0);
        chk("rst_odata",   32'(out_data),    32'd0);
        chk("rst_sync",    32'(sync_cnt),    32'd0);
        chk("rst_lost",    32'(lost_cycles), 32'd0);
        chk("rst_ovf",     32'(ovf_pulse),   32'd0);
        chk("rst_pkterr",  32'(pkt_err),     32'd0);
        rst = 1'b0;

        // 1: two back-to-back runs, each replaying the previous sample
        send(32'h0300000A, 1'b0);
        chk("t1_valid_after_accept", 32'(out_valid), 32'd1);
        collect("t1a", 24'h000000, 3, 1'b0);
        send(32'h050000FF, 1'b0);
        collect("t1b", 24'h00000A, 5, 1'b0);

        // 2: stalled output
        send(32'h04000011, 1'b0);
        collect("t2", 24'h0000FF, 4, 1'b1);

        // 3: sync words leave prev_data untouched
        send(32'h00000000, 1'b0);
        chk("t3_sync1_novalid", 32'(out_valid), 32'd0);
        send(32'h00000000, 1'b0);
        chk("t3_sync2_novalid", 32'(out_valid), 32'd0);
        chk("t3_sync_cnt", 32'(sync_cnt), 32'd2);
        send(32'h02000022, 1'b0);
        collect("t3", 24'h000011, 2, 1'b0);

        // 4: FIFO-full markers and saturation
        send(32'h00000010, 1'b0);
        chk("t4_ovf1",  32'(ovf_pulse),   32'd1);
        chk("t4_lost1", 32'(lost_cycles), 32'h000010);
        chk("t4_novalid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t4_ovf_drop", 32'(ovf_pulse), 32'd0);
        send(32'h00FFFFFF, 1'b0);
        chk("t4_ovf2",  32'(ovf_pulse),   32'd1);
        chk("t4_lost_sat", 32'(lost_cycles), 32'hFFFFFF);
        send(32'h00000005, 1'b0);
        chk("t4_lost_hold", 32'(lost_cycles), 32'hFFFFFF);

        // 5: packet length checking
        send(32'h00000000, 1'b1);
        chk("t5_no_err_len0", 32'(pkt_err), 32'd0);
        pkt_len = 8'd8;
        for (int i = 1; i <= 5; i++) send(32'h00000000, 1'b0);
        chk("t5_pre_err", 32'(pkt_err), 32'd0);
        send(32'h00000000, 1'b1);
        chk("t5_early_tlast", 32'(pkt_err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_clr", 32'(pkt_err), 32'd0);
        for (int i = 1; i <= 8; i++) send(32'h00000000, (i == 8));
        chk("t5_clean_pkt", 32'(pkt_err), 32'd0);
        for (int i = 1; i <= 8; i++) send(32'h00000000, 1'b0);
        chk("t5_missing_tlast", 32'(pkt_err), 32'd1);
        err_clr = 1'b1;
        send(32'h00000000, 1'b1);
        err_clr = 1'b0;
        chk("t5_err_beats_clr", 32'(pkt_err), 32'd1);
        pkt_len = 8'd0;

        // 6: reset in the middle of a replay
        send(32'h05000033, 1'b0);
        chk("t6_data", 32'(out_data), 32'h000022);
        @(negedge clk);
        @(negedge clk);
        chk("t6_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_ovalid", 32'(out_valid),   32'd0);
        chk("t6_rst_odata",  32'(out_data),    32'd0);
        chk("t6_rst_tready", 32'(s_tready),    32'd0);
        chk("t6_rst_lost",   32'(lost_cycles), 32'd0);
        chk("t6_rst_pkterr", 32'(pkt_err),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h02000044, 1'b0);
        collect("t6", 24'h000000, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
